// File: rtl/dmem_rsp.sv
// dmem_rsp - data-memory responder for the RV32I core.
//
// Word-organised RAM serving decode-stage loads with a fixed programmable
// latency and execute-stage stores that commit in one cycle.
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words; word index = addr[31:2] mod DEPTH_WORDS
//   RD_LATENCY  : cycles from read acceptance to rd_valid_o (1..15)
//
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   rd_req_i/rd_addr_i/rd_func3_i            : load request (LB/LH/LW/LBU/LHU)
//   wr_req_i/wr_addr_i/wr_data_i/wr_func3_i  : store request (SB/SH/SW)
//   rd_data_o   : extended load result, held until the next rd_valid_o
//   rd_valid_o  : one-cycle pulse marking rd_data_o valid
//   busy_o      : a read is outstanding; requests are ignored
//   misalign_o  : misaligned-access error pulse
//
// Build option:
//   DMEM_MISALIGN_CHK_EN : when defined, misaligned accesses are flagged on
//   misalign_o (reads return 0, writes are dropped). When undefined, low
//   address bits that break alignment are ignored and misalign_o is 0.
module dmem_rsp #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req_i,
  input  logic [31:0] rd_addr_i,
  input  logic [2:0]  rd_func3_i,
  input  logic        wr_req_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [2:0]  wr_func3_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        busy_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(RD_LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  func3_q, func3_d;
  logic        rd_mis_q, rd_mis_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic          accept;
  logic          wr_en;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_lanes;
  logic [AW-1:0] wr_idx;
  logic          rd_mis_in;
  logic          wr_mis_in;
  logic          sample_en;
  logic [31:0]   sample_addr;
  logic [2:0]    sample_func3;
  logic          sample_mis;
  logic [AW-1:0] sample_idx;
  logic [31:0]   sample_word;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2] % 30'(DEPTH_WORDS);
    return w[AW-1:0];
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] lanes,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = lanes[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return '0;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_CHK_EN
  logic wr_mis_q, wr_mis_d;

  always_comb begin
    rd_mis_in = 1'b0;
    case (rd_func3_i)
      3'b001, 3'b101: rd_mis_in = rd_addr_i[0];
      3'b010:         rd_mis_in = (rd_addr_i[1:0] != 2'b00);
      default:        rd_mis_in = 1'b0;
    endcase
    wr_mis_in = 1'b0;
    case (wr_func3_i)
      3'b001:  wr_mis_in = wr_addr_i[0];
      3'b010:  wr_mis_in = (wr_addr_i[1:0] != 2'b00);
      default: wr_mis_in = 1'b0;
    endcase
    wr_mis_d = wr_req_i && accept && !rst && wr_mis_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_mis_q <= 1'b0;
    else     wr_mis_q <= wr_mis_d;
  end

  assign misalign_o = (rd_valid_o && rd_mis_q) || wr_mis_q;
`else
  assign rd_mis_in  = 1'b0;
  assign wr_mis_in  = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign accept = (state_q != WAIT);

  // Store lane selection: data is replicated across lanes, mask picks them.
  always_comb begin
    wr_mask  = '0;
    wr_lanes = wr_data_i;
    case (wr_func3_i)
      3'b000: begin
        wr_mask  = 4'b0001 << wr_addr_i[1:0];
        wr_lanes = {4{wr_data_i[7:0]}};
      end
      3'b001: begin
        wr_mask  = wr_addr_i[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wr_data_i[15:0]}};
      end
      3'b010:  wr_mask = 4'b1111;
      default: wr_mask = '0;
    endcase
    wr_idx = word_idx(wr_addr_i);
    wr_en  = wr_req_i && accept && !rst && (wr_mask != '0) && !wr_mis_in;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= merge_lanes(mem[wr_idx], wr_lanes, wr_mask);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    func3_d      = func3_q;
    rd_mis_d     = rd_mis_q;
    sample_en    = 1'b0;
    sample_addr  = addr_q;
    sample_func3 = func3_q;
    sample_mis   = rd_mis_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (rd_req_i) begin
          addr_d   = rd_addr_i;
          func3_d  = rd_func3_i;
          rd_mis_d = rd_mis_in;
          if (RD_LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d      = RESP;
            sample_en    = 1'b1;
            sample_addr  = rd_addr_i;
            sample_func3 = rd_func3_i;
            sample_mis   = rd_mis_in;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d   = RESP;
          sample_en = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A store accepted on the same edge that samples the RAM (only possible
  // with RD_LATENCY=1) is forwarded so the read sees the new data.
  always_comb begin
    sample_idx  = word_idx(sample_addr);
    sample_word = mem[sample_idx];
    if (wr_en && (wr_idx == sample_idx)) begin
      sample_word = merge_lanes(sample_word, wr_lanes, wr_mask);
    end
    rd_data_d = rd_data_q;
    if (sample_en) begin
      rd_data_d = sample_mis ? '0
                             : load_extract(sample_word, sample_func3, sample_addr[1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      func3_q   <= '0;
      rd_mis_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      func3_q   <= func3_d;
      rd_mis_q  <= rd_mis_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = (state_q == RESP);
  assign busy_o     = (state_q == WAIT);

endmodule

// File: tb/tb_dmem_rsp.sv
// Directed bench for dmem_rsp: instance a uses RD_LATENCY=2, instance b
// uses RD_LATENCY=1. Inputs change and outputs are sampled on the falling edge.
module tb_dmem_rsp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_rd_req, a_wr_req, a_rd_valid, a_busy, a_mis;
  logic [31:0] a_rd_addr, a_wr_addr, a_wr_data, a_rd_data;
  logic [2:0]  a_rd_func3, a_wr_func3;
  logic        b_rd_req, b_wr_req, b_rd_valid, b_busy, b_mis;
  logic [31:0] b_rd_addr, b_wr_addr, b_wr_data, b_rd_data;
  logic [2:0]  b_rd_func3, b_wr_func3;

  int checks = 0;
  int errors = 0;

  dmem_rsp #(.DEPTH_WORDS(4096), .RD_LATENCY(2)) u_a (
    .clk(clk), .rst(rst),
    .rd_req_i(a_rd_req), .rd_addr_i(a_rd_addr), .rd_func3_i(a_rd_func3),
    .wr_req_i(a_wr_req), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
    .wr_func3_i(a_wr_func3),
    .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid), .busy_o(a_busy),
    .misalign_o(a_mis)
  );

  dmem_rsp #(.DEPTH_WORDS(4096), .RD_LATENCY(1)) u_b (
    .clk(clk), .rst(rst),
    .rd_req_i(b_rd_req), .rd_addr_i(b_rd_addr), .rd_func3_i(b_rd_func3),
    .wr_req_i(b_wr_req), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
    .wr_func3_i(b_wr_func3),
    .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .busy_o(b_busy),
    .misalign_o(b_mis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read on instance a: request in the current cycle, busy next, valid after.
  task automatic a_read(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] exp, input logic exp_mis);
    chk({tag, "_idle_busy"}, 32'(a_busy), 32'd0);
    a_rd_req = 1'b1; a_rd_addr = addr; a_rd_func3 = f3;
    @(negedge clk);
    a_rd_req = 1'b0; a_rd_addr = 32'hFFFF_FFFF; a_rd_func3 = 3'b111;
    chk({tag, "_wait_busy"}, 32'(a_busy), 32'd1);
    chk({tag, "_wait_valid"}, 32'(a_rd_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(a_rd_valid), 32'd1);
    chk({tag, "_data"}, a_rd_data, exp);
    chk({tag, "_mis"}, 32'(a_mis), 32'(exp_mis));
    chk({tag, "_resp_busy"}, 32'(a_busy), 32'd0);
    @(negedge clk);
    chk({tag, "_after_valid"}, 32'(a_rd_valid), 32'd0);
    chk({tag, "_hold"}, a_rd_data, exp);
  endtask

  task automatic a_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    a_wr_req = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_func3 = f3;
    @(negedge clk);
    a_wr_req = 1'b0;
  endtask

  task automatic b_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    b_wr_req = 1'b1; b_wr_addr = addr; b_wr_data = data; b_wr_func3 = f3;
    @(negedge clk);
    b_wr_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_rd_req = 1'b0; a_rd_addr = '0; a_rd_func3 = '0;
    a_wr_req = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_func3 = '0;
    b_rd_req = 1'b0; b_rd_addr = '0; b_rd_func3 = '0;
    b_wr_req = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_func3 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_a_data", a_rd_data, 32'd0);
    chk("rst_a_valid", 32'(a_rd_valid), 32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_mis", 32'(a_mis), 32'd0);
    chk("rst_b_valid", 32'(b_rd_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic store/load and extraction
    a_write(32'h10, 32'h8000_00F1, 3'b010);
    a_read("lw10", 32'h10, 3'b010, 32'h8000_00F1, 1'b0);
    a_read("lb10", 32'h10, 3'b000, 32'hFFFF_FFF1, 1'b0);
    a_read("lbu10", 32'h10, 3'b100, 32'h0000_00F1, 1'b0);
    a_read("lh12", 32'h12, 3'b001, 32'hFFFF_8000, 1'b0);
    a_read("lhu12", 32'h12, 3'b101, 32'h0000_8000, 1'b0);
    a_read("lb13", 32'h13, 3'b000, 32'hFFFF_FF80, 1'b0);
    a_read("unk_f3", 32'h10, 3'b011, 32'h0000_0000, 1'b0);

    // Simultaneous store and load to the same word
    a_wr_req = 1'b1; a_wr_addr = 32'h11; a_wr_data = 32'h0000_00AB; a_wr_func3 = 3'b000;
    a_read("sb_lw", 32'h10, 3'b010, 32'h8000_ABF1, 1'b0);
    a_wr_req = 1'b0;

    // Store while busy is ignored
    a_rd_req = 1'b1; a_rd_addr = 32'h10; a_rd_func3 = 3'b010;
    @(negedge clk);
    a_rd_req = 1'b0;
    chk("busy_wr_busy", 32'(a_busy), 32'd1);
    a_wr_req = 1'b1; a_wr_addr = 32'h10; a_wr_data = 32'hDEAD_BEEF; a_wr_func3 = 3'b010;
    @(negedge clk);
    a_wr_req = 1'b0;
    chk("busy_wr_valid", 32'(a_rd_valid), 32'd1);
    chk("busy_wr_data", a_rd_data, 32'h8000_ABF1);
    @(negedge clk);
    a_read("after_busy_wr", 32'h10, 3'b010, 32'h8000_ABF1, 1'b0);

    // Reset during WAIT aborts the read, RAM is retained
    a_rd_req = 1'b1; a_rd_addr = 32'h14; a_rd_func3 = 3'b010;
    @(negedge clk);
    a_rd_req = 1'b0;
    chk("abort_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rst_busy", 32'(a_busy), 32'd0);
    chk("abort_rst_data", a_rd_data, 32'd0);
    chk("abort_rst_valid", 32'(a_rd_valid), 32'd0);
    @(negedge clk);
    chk("abort_no_valid", 32'(a_rd_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_valid2", 32'(a_rd_valid), 32'd0);
    a_read("retained", 32'h10, 3'b010, 32'h8000_ABF1, 1'b0);

    // Misalignment handling
`ifdef DMEM_MISALIGN_CHK_EN
    a_read("mis_lw12", 32'h12, 3'b010, 32'h0000_0000, 1'b1);
    a_wr_req = 1'b1; a_wr_addr = 32'h13; a_wr_data = 32'h0000_1234; a_wr_func3 = 3'b001;
    @(negedge clk);
    a_wr_req = 1'b0;
    chk("mis_sh_pulse", 32'(a_mis), 32'd1);
    @(negedge clk);
    chk("mis_sh_pulse_end", 32'(a_mis), 32'd0);
    a_read("mis_sh_ram", 32'h10, 3'b010, 32'h8000_ABF1, 1'b0);
`else
    a_read("nomis_lw12", 32'h12, 3'b010, 32'h8000_ABF1, 1'b0);
    a_wr_req = 1'b1; a_wr_addr = 32'h13; a_wr_data = 32'h0000_1234; a_wr_func3 = 3'b001;
    @(negedge clk);
    a_wr_req = 1'b0;
    chk("nomis_sh_flag", 32'(a_mis), 32'd0);
    @(negedge clk);
    a_read("nomis_sh_ram", 32'h10, 3'b010, 32'h1234_ABF1, 1'b0);
`endif

    // Latency-1 instance: back-to-back loads
    b_write(32'h10, 32'h1111_1111, 3'b010);
    b_write(32'h14, 32'h2222_2222, 3'b010);
    b_rd_req = 1'b1; b_rd_addr = 32'h10; b_rd_func3 = 3'b010;
    @(negedge clk);
    chk("b2b_v0", 32'(b_rd_valid), 32'd1);
    chk("b2b_d0", b_rd_data, 32'h1111_1111);
    chk("b2b_busy0", 32'(b_busy), 32'd0);
    b_rd_addr = 32'h14;
    @(negedge clk);
    b_rd_req = 1'b0;
    chk("b2b_v1", 32'(b_rd_valid), 32'd1);
    chk("b2b_d1", b_rd_data, 32'h2222_2222);
    chk("b2b_busy1", 32'(b_busy), 32'd0);
    @(negedge clk);
    chk("b2b_v2", 32'(b_rd_valid), 32'd0);
    chk("b2b_hold", b_rd_data, 32'h2222_2222);

    // Latency-1 same-cycle store forwarding
    b_wr_req = 1'b1; b_wr_addr = 32'h12; b_wr_data = 32'h0000_0055; b_wr_func3 = 3'b000;
    b_rd_req = 1'b1; b_rd_addr = 32'h10; b_rd_func3 = 3'b010;
    @(negedge clk);
    b_wr_req = 1'b0; b_rd_req = 1'b0;
    chk("fwd_valid", 32'(b_rd_valid), 32'd1);
    chk("fwd_data", b_rd_data, 32'h1155_1111);

    // Address wrap: word index DEPTH_WORDS aliases index 0
    b_write(32'h4000, 32'hCAFE_F00D, 3'b010);
    b_rd_req = 1'b1; b_rd_addr = 32'h0; b_rd_func3 = 3'b010;
    @(negedge clk);
    b_rd_req = 1'b0;
    chk("wrap_valid", 32'(b_rd_valid), 32'd1);
    chk("wrap_data", b_rd_data, 32'hCAFE_F00D);
    chk("wrap_busy", 32'(b_busy), 32'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_rsp.md
Name: dmem_rsp

Overview:
Data-memory responder for the RV32I core. It is the memory end of the decode-stage load request (mem_rd_req/mem_rd_addr) and of the execute-stage store request. It holds a word-organised RAM and services reads with a programmable fixed latency. Read data is byte/half/word extracted and sign- or zero-extended per load func3. Stores commit in one cycle with byte lanes selected by store func3.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words in the RAM; word index = addr[31:2] modulo DEPTH_WORDS (wraps).
RD_LATENCY, 2, cycles from read acceptance to rd_valid_o; legal range 1..15.

Ports:
clk  input  1  core clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
rd_req_i  input  1  load request; sampled only when the block is idle.
rd_addr_i  input  32  load byte address.
rd_func3_i  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
wr_req_i  input  1  store request; sampled only when the block is idle.
wr_addr_i  input  32  store byte address.
wr_data_i  input  32  store data; the low byte or half is used for SB/SH.
wr_func3_i  input  3  store type: 000 SB, 001 SH, 010 SW.
rd_data_o  output  32  extended load result; holds its value until the next rd_valid_o.
rd_valid_o  output  1  one-cycle pulse; rd_data_o is valid.
busy_o  output  1  high while a read is outstanding; requesters must hold their requests.
misalign_o  output  1  one-cycle error pulse (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-high; the reset port is named rst. All outputs go to 0, the FSM goes to IDLE and the latency counter clears. RAM contents are not cleared. Asserting reset mid-read aborts the read with no rd_valid_o.
- FSM states:
  - IDLE: accepts requests.
  - WAIT: counting. IDLE->WAIT on an accepted read if RD_LATENCY>1; otherwise IDLE->RESP.
  - RESP: one cycle; rd_valid_o=1; returns to IDLE. A new request may be accepted during RESP (back-to-back).
- Timing: a read accepted at edge T gives rd_valid_o high in cycle T+RD_LATENCY. busy_o = (state==WAIT).
- Counter: loaded with RD_LATENCY-1 on acceptance, decrements in WAIT. WAIT->RESP when it reaches 1.
- Read address and func3 are latched at acceptance. Later changes on the inputs do not affect the result.
- The RAM word is sampled on the cycle entering RESP. Extraction:
  - LB/LBU: byte at addr[1:0].
  - LH/LHU: half at addr[1].
  - LW: full word.
  - Sign extension from bit 7 or 15 for LB/LH; zero extension for LBU/LHU.
  - Unknown load func3: rd_data_o=0, rd_valid_o still pulses.
- Stores: accepted in IDLE or RESP only. Write occurs on the accepting edge with a byte mask:
  - SB: 1 lane at addr[1:0].
  - SH: 2 lanes at addr[1].
  - SW: all 4 lanes.
  - Unknown store func3: dropped.
  - wr_req_i while busy_o=1 is ignored.
- Simultaneous rd_req_i and wr_req_i: both are accepted. The write commits first, so a read of the same word returns the new data.
- Address wrap: word index DEPTH_WORDS aliases to index 0.

Optional Feature:
DMEM_MISALIGN_CHK_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is misaligned.
  - Misaligned read: completes with normal timing, rd_data_o=0, misalign_o pulses together with rd_valid_o.
  - Misaligned write: RAM unchanged; misalign_o pulses the cycle after acceptance.
- Undefined: low address bits that break alignment are ignored (access is aligned down to the half or word). misalign_o is tied to 0.

Test Plan:
1. Reset, SW 0x8000_00F1 to 0x10, then LW 0x10 at T -> rd_valid_o at T+2 with rd_data_o=0x8000_00F1; busy_o high only in T+1.
2. Same word: LB 0x10 -> 0xFFFF_FFF1; LBU 0x10 -> 0x0000_00F1; LH 0x12 -> 0xFFFF_8000; LHU 0x12 -> 0x0000_8000.
3. SB 0xAB to 0x11 plus LW 0x10 in the same cycle -> 0x8000_ABF1. Also, a wr_req_i asserted while busy_o=1 leaves the RAM unchanged.
4. RD_LATENCY=1 with back-to-back loads of 0x10 and 0x14 -> rd_valid_o high on two consecutive cycles, busy_o never high. Also, a store to 4*DEPTH_WORDS is read back at address 0.
5. Assert rst in the WAIT state -> no rd_valid_o, all outputs 0; a following LW 0x10 returns the pre-reset value (RAM retained).
6. With DMEM_MISALIGN_CHK_EN, LW 0x12 -> rd_data_o=0 with misalign_o and rd_valid_o together; SH to 0x13 -> misalign_o pulse next cycle, RAM unchanged. Without the macro, LW 0x12 returns the word at 0x10.
